bram_capture_buf: RTL and testbench
===================================

Name: bram_capture_buf

Overview:
- Parametrised circular capture buffer on inferred block RAM, for the Shapiro-Rudin-Park time synchronizer sample/correlation path.
- Continuously records a sample stream into a ring once armed and keeps PRE_TRIG samples of history.
- On a qualified trigger, finishes the record and freezes.
- Software or the sync engine then reads the record by trigger-relative index through a registered read port.

Parameters:
DATA_W, 32, sample width in bits
ADDR_W, 12, RAM address width
DEPTH, 2096, ring size in words; 2 <= DEPTH <= 2**ADDR_W
PRE_TRIG, 1024, samples kept before the trigger sample; 1 <= PRE_TRIG < DEPTH
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
arm  in  1  pulse: start or restart a capture
in_valid  in  1  sample strobe
in_data  in  DATA_W  sample
trig  in  1  trigger; qualified only with in_valid in WAIT_TRIG
rd_en  in  1  read request
rd_addr  in  ADDR_W  trigger-relative index; 0 is the oldest sample, PRE_TRIG is the trigger sample
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid strobe
rd_err  out  1  with rd_valid: rd_addr >= DEPTH
state  out  2  0 IDLE, 1 PRE, 2 WAIT_TRIG, 3 DONE
done  out  1  high in DONE
trig_ptr  out  ADDR_W  physical address of the trigger sample

Behaviour:
- Reset (asynchronous): state IDLE; wr_ptr, pre_cnt, post_cnt, trig_ptr, rd_data, rd_valid, rd_err and done all 0. RAM contents are not reset.
- Write rule:
  - In PRE, WAIT_TRIG and POST (POST is internal, reported on state as 2): in_valid writes in_data to RAM[wr_ptr].
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - No writes in IDLE or DONE.
- FSM:
  - IDLE: arm -> PRE, with wr_ptr=0 and counters cleared.
  - PRE: each write increments pre_cnt. The write that makes pre_cnt == PRE_TRIG moves to WAIT_TRIG. trig is ignored.
  - WAIT_TRIG: writes wrap freely. trig & in_valid means:
    - this sample is written at wr_ptr;
    - trig_ptr <= wr_ptr;
    - post_cnt <= 1;
    - go to POST.
    - trig without in_valid is ignored.
  - POST: each write increments post_cnt. When post_cnt reaches DEPTH-PRE_TRIG, meaning the trigger sample plus DEPTH-PRE_TRIG-1 later samples have been written, go to DONE. If DEPTH-PRE_TRIG == 1, the trigger write goes directly to DONE.
  - DONE: frozen, done=1. arm -> PRE (restart).
- arm in PRE, WAIT_TRIG or POST aborts the capture and restarts PRE with counters cleared and wr_ptr=0. arm outranks trig in the same cycle.
- A sample arriving in the same cycle as arm is not written.
- Read port:
  - Readable in any state; data is meaningful only in DONE.
  - start = trig_ptr - PRE_TRIG mod DEPTH.
  - phys = start + rd_addr; subtract DEPTH once if phys >= DEPTH. Compute phys at ADDR_W+1 bits.
  - Latency: rd_valid asserts 1 cycle after rd_en (OUT_REG=0) or 2 cycles after (OUT_REG=1). Back-to-back reads give one result per cycle.
  - rd_addr >= DEPTH: rd_valid=1, rd_err=1, rd_data=0, and no RAM read.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous read and write to the same physical address: read returns the old contents (read-first).
- RAM inferred as simple dual port (one write port, one read port), with no reset on the RAM array.

Test Plan (DEPTH=16, PRE_TRIG=4, in_data = running sample count starting at 0, unless stated):
- Reset mid-POST, then deassert -> state=0, done=0, rd_valid=0, trig_ptr=0. A following arm restarts with wr_ptr=0.
- arm; 10 valid samples; trig on sample 10 -> trig_ptr=10; DONE after sample 21. Reads of rd_addr 0..15 return 6..21 in order; rd_valid 1 cycle after each rd_en.
- Wrap: arm; 30 samples before trig on sample 30 (trig_ptr=14). Reads of rd_addr 0..15 return 26..41. The physical wrap 15->0 is inside the record.
- trig asserted during PRE (samples 0..3) and trig without in_valid in WAIT_TRIG -> both ignored. A later qualified trig at sample 7 gives rd_addr 4 = 7.
- arm and qualified trig in the same cycle during WAIT_TRIG -> restart to PRE, no trigger recorded, that sample not written. In DONE, arm re-captures and the old record is overwritten.
- OUT_REG=1: back-to-back reads of rd_addr 0,1,2 -> data on cycles +2,+3,+4. rd_addr=16 -> rd_valid=1, rd_err=1, rd_data=0.

Source files
------------

// File: rtl/bram_capture_buf.sv
// -----------------------------------------------------------------------------
// bram_capture_buf
//   Circular capture buffer on inferred simple-dual-port block RAM for the
//   Shapiro-Rudin-Park time synchronizer sample/correlation path. Once armed it
//   records the sample stream into a ring. It keeps PRE_TRIG samples of history
//   ahead of a qualified trigger, finishes the record after the trigger, and
//   then freezes. The record is read back by trigger-relative index.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   rst       : asynchronous active-high reset
//   arm       : pulse, start or restart a capture (outranks trig)
//   in_valid  : sample strobe
//   in_data   : sample
//   trig      : trigger, qualified by in_valid while waiting for a trigger
//   rd_en     : read request
//   rd_addr   : trigger-relative index (0 = oldest, PRE_TRIG = trigger sample)
//   rd_data   : read data, holds its last value while rd_valid is low
//   rd_valid  : read data strobe, 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1)
//               after rd_en
//   rd_err    : with rd_valid, the index was >= DEPTH (rd_data is then 0)
//   state     : 0 IDLE, 1 PRE, 2 WAIT_TRIG/POST, 3 DONE
//   done      : high while the record is complete and frozen
//   trig_ptr  : physical RAM address of the trigger sample
// -----------------------------------------------------------------------------
module bram_capture_buf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 2096,
  parameter int PRE_TRIG = 1024,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              trig,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] trig_ptr
);

  // POST is internal only; it is reported on the state port as 2.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;

  // Address arithmetic is one bit wider than the RAM address so that
  // start + rd_addr cannot overflow before the single modulo subtraction.
  localparam int            CW      = ADDR_W + 1;
  localparam int            IW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_X = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_X  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PRE_X   = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_X  = CW'(DEPTH - PRE_TRIG);

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [CW-1:0]     pre_cnt_q,  pre_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic              we;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic              capturing;

  assign wr_ptr_inc = ({1'b0, wr_ptr_q} == LAST_X) ? '0 : wr_ptr_q + ADDR_W'(1);
  assign capturing  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    we         = 1'b0;

    if (arm) begin
      // Restart from any state; a sample arriving with arm is dropped.
      state_d    = S_PRE;
      wr_ptr_d   = '0;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
    end else if (in_valid && capturing) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_inc;
      case (state_q)
        S_PRE: begin
          pre_cnt_d = pre_cnt_q + CW'(1);
          if (pre_cnt_d == PRE_X) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (trig) begin
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = CW'(1);
            // With a single post-trigger slot the trigger sample completes it.
            state_d    = (POST_X == CW'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q + CW'(1);
          if (post_cnt_d == POST_X) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  assign state    = (state_q == S_POST) ? 2'd2 : state_q[1:0];
  assign done     = (state_q == S_DONE);
  assign trig_ptr = trig_ptr_q;

  // ---------------------------------------------------------------------------
  // Trigger-relative to physical address translation
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     start, phys_raw, phys;
  logic [ADDR_W-1:0] rd_phys;
  logic              rd_oob;

  always_comb begin
    start    = ({1'b0, trig_ptr_q} >= PRE_X) ? {1'b0, trig_ptr_q} - PRE_X
                                             : {1'b0, trig_ptr_q} + DEPTH_X - PRE_X;
    phys_raw = start + {1'b0, rd_addr};
    phys     = (phys_raw >= DEPTH_X) ? phys_raw - DEPTH_X : phys_raw;
    rd_phys  = ADDR_W'(phys);
    rd_oob   = ({1'b0, rd_addr} >= DEPTH_X);
  end

  // ---------------------------------------------------------------------------
  // Simple dual-port RAM, read-first on address collision
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  // NOTE: the array and its read register carry no reset; a reset here would
  // prevent block-RAM inference and its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem_q[IW'(wr_ptr_q)] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en && !rd_oob) ram_rd_q <= mem_q[IW'(rd_phys)];
  end

  // Stage-1 read qualifiers travel alongside the RAM read register.
  logic s1_valid_q, s1_valid_d;
  logic s1_err_q,   s1_err_d;
  logic [DATA_W-1:0] s1_data;

  assign s1_valid_d = rd_en;
  assign s1_err_d   = rd_en & rd_oob;
  assign s1_data    = s1_err_q ? '0 : ram_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q,   out_err_d;

    always_comb begin
      out_data_d  = s1_valid_q ? s1_data : out_data_q;
      out_valid_d = s1_valid_q;
      out_err_d   = s1_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
        out_err_q   <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
        out_err_q   <= out_err_d;
      end
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
    assign rd_err   = out_err_q;
  end else begin : g_no_out_reg
    // The RAM read register is not reset and is not updated on an error read,
    // so the last delivered word is kept separately for the hold behaviour.
    logic [DATA_W-1:0] hold_q, hold_d;

    assign hold_d = s1_valid_q ? s1_data : hold_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
    end

    assign rd_data  = s1_valid_q ? s1_data : hold_q;
    assign rd_valid = s1_valid_q;
    assign rd_err   = s1_err_q;
  end

endmodule

// File: tb/tb_bram_capture_buf.sv
// -----------------------------------------------------------------------------
// tb_bram_capture_buf
//   Directed bench for bram_capture_buf with DEPTH=16, PRE_TRIG=4. Two copies
//   share all inputs: u0 without and u1 with the output register stage.
//   Sample values are the running sample count of each capture.
// -----------------------------------------------------------------------------
module tb_bram_capture_buf;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              trig;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] r0_data,  r1_data;
  logic              r0_valid, r1_valid;
  logic              r0_err,   r1_err;
  logic [1:0]        st0,      st1;
  logic              done0,    done1;
  logic [ADDR_W-1:0] tp0,      tp1;

  int n_checks = 0;
  int n_err    = 0;

  bram_capture_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .OUT_REG(0)
  ) u0 (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_data(in_data),
    .trig(trig), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(r0_data),
    .rd_valid(r0_valid), .rd_err(r0_err), .state(st0), .done(done0), .trig_ptr(tp0)
  );

  bram_capture_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .OUT_REG(1)
  ) u1 (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_data(in_data),
    .trig(trig), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(r1_data),
    .rd_valid(r1_valid), .rd_err(r1_err), .state(st1), .done(done1), .trig_ptr(tp1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Samples first..first+count-1, value base+index, trigger on index trig_at.
  task automatic feed(input int first, input int count, input int trig_at, input int base);
    for (int i = first; i < first + count; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(base + i);
      trig     = (i == trig_at);
      tick();
    end
    in_valid = 1'b0;
    trig     = 1'b0;
  endtask

  // Back-to-back read of the whole record; expects values first..first+15.
  task automatic read_all(input string tag, input int first);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(i);
      tick();
      check({tag, "_v0"}, 32'(r0_valid), 32'd1);
      check({tag, "_d0"}, r0_data, 32'(first + i));
      if (i > 0) check({tag, "_d1"}, r1_data, 32'(first + i - 1));
    end
    rd_en = 1'b0;
    tick();
    check({tag, "_idle_v0"}, 32'(r0_valid), 32'd0);
    check({tag, "_hold_d0"}, r0_data, 32'(first + DEPTH - 1));
    check({tag, "_last_v1"}, 32'(r1_valid), 32'd1);
    check({tag, "_last_d1"}, r1_data, 32'(first + DEPTH - 1));
    tick();
  endtask

  task automatic read_one(input string tag, input int addr, input int exp_d, input logic exp_e);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(addr);
    tick();
    rd_en = 1'b0;
    check({tag, "_v0"}, 32'(r0_valid), 32'd1);
    check({tag, "_e0"}, 32'(r0_err), 32'(exp_e));
    check({tag, "_d0"}, r0_data, 32'(exp_d));
    check({tag, "_early_v1"}, 32'(r1_valid), 32'd0);
    tick();
    check({tag, "_v1"}, 32'(r1_valid), 32'd1);
    check({tag, "_e1"}, 32'(r1_err), 32'(exp_e));
    check({tag, "_d1"}, r1_data, 32'(exp_d));
    check({tag, "_after_v0"}, 32'(r0_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; in_data = '0; trig = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    tick();
    tick();
    check("rst_state", 32'(st0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_rd_valid", 32'(r0_valid), 32'd0);
    check("rst_trig_ptr", 32'(tp0), 32'd0);
    check("rst_rd_data0", r0_data, 32'd0);
    check("rst_rd_data1", r1_data, 32'd0);
    rst = 1'b0;
    tick();

    // Basic capture: trigger on sample 10, record = samples 6..21.
    arm_pulse();
    check("a_pre", 32'(st0), 32'd1);
    feed(0, 21, 10, 0);
    check("a_post_state", 32'(st0), 32'd2);
    check("a_post_done", 32'(done0), 32'd0);
    feed(21, 1, -1, 0);
    check("a_done_state", 32'(st0), 32'd3);
    check("a_done", 32'(done0), 32'd1);
    check("a_trig_ptr", 32'(tp0), 32'd10);
    check("a_done_state1", 32'(st1), 32'd3);
    feed(22, 3, -1, 0);   // frozen: these must not land in the ring
    check("a_frozen", 32'(st0), 32'd3);
    read_all("a_rd", 6);

    // Asynchronous reset in the middle of POST with a read result in flight.
    arm_pulse();
    feed(0, 12, 10, 0);
    check("r_post_state", 32'(st0), 32'd2);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(3);
    tick();
    rd_en = 1'b0;
    check("r_pre_valid", 32'(r0_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("r_state", 32'(st0), 32'd0);
    check("r_done", 32'(done0), 32'd0);
    check("r_rd_valid", 32'(r0_valid), 32'd0);
    check("r_trig_ptr", 32'(tp0), 32'd0);
    #1 rst = 1'b0;
    tick();

    // Wrap: trigger on sample 30 at physical 14, record = samples 26..41.
    arm_pulse();
    feed(0, 42, 30, 0);
    check("w_state", 32'(st0), 32'd3);
    check("w_trig_ptr", 32'(tp0), 32'd14);
    read_all("w_rd", 26);

    // trig during PRE and trig without in_valid are both ignored.
    arm_pulse();
    for (int i = 0; i < PRE_TRIG; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      trig     = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    trig     = 1'b0;
    check("i_wait_state", 32'(st0), 32'd2);
    check("i_no_pre_trig", 32'(tp0), 32'd14);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("i_unqual_state", 32'(st0), 32'd2);
    check("i_unqual_tp", 32'(tp0), 32'd14);
    feed(4, 3, -1, 0);
    check("i_still_wait", 32'(st0), 32'd2);
    feed(7, 12, 7, 0);
    check("i_done", 32'(st0), 32'd3);
    check("i_trig_ptr", 32'(tp0), 32'd7);
    read_one("i_rd4", 4, 7, 1'b0);
    read_one("i_rd0", 0, 3, 1'b0);

    // arm with a qualified trigger in WAIT_TRIG: restart wins, sample dropped.
    arm_pulse();
    feed(0, 6, -1, 0);
    check("x_wait", 32'(st0), 32'd2);
    arm = 1'b1; in_valid = 1'b1; in_data = DATA_W'(100); trig = 1'b1;
    tick();
    arm = 1'b0; in_valid = 1'b0; trig = 1'b0;
    check("x_restart", 32'(st0), 32'd1);
    check("x_tp_kept", 32'(tp0), 32'd7);
    feed(0, 3, -1, 0);
    check("x_pre_count", 32'(st0), 32'd1);
    feed(3, 1, -1, 0);
    check("x_pre_full", 32'(st0), 32'd2);
    feed(4, 12, 4, 0);
    check("x_done", 32'(st0), 32'd3);
    check("x_trig_ptr", 32'(tp0), 32'd4);
    read_one("x_rd0", 0, 0, 1'b0);
    read_one("x_rd15", 15, 15, 1'b0);

    // Re-capture from DONE overwrites the old record.
    arm_pulse();
    check("c_restart", 32'(st0), 32'd1);
    feed(0, 16, 4, 200);
    check("c_done", 32'(st0), 32'd3);
    check("c_trig_ptr", 32'(tp0), 32'd4);
    read_one("c_rd0", 0, 200, 1'b0);
    read_one("c_rd9", 9, 209, 1'b0);

    // Output-register pipeline: reads 0,1,2 back to back.
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(0);
    tick();
    check("o_lat_v1", 32'(r1_valid), 32'd0);
    rd_addr = ADDR_W'(1);
    tick();
    check("o_v1_0", 32'(r1_valid), 32'd1);
    check("o_d1_0", r1_data, 32'd200);
    rd_addr = ADDR_W'(2);
    tick();
    rd_en = 1'b0;
    check("o_d1_1", r1_data, 32'd201);
    tick();
    check("o_v1_2", 32'(r1_valid), 32'd1);
    check("o_d1_2", r1_data, 32'd202);
    tick();
    check("o_idle_v1", 32'(r1_valid), 32'd0);
    check("o_hold_d1", r1_data, 32'd202);

    // Out-of-range index.
    read_one("e_rd16", 16, 0, 1'b1);
    tick();
    check("e_hold_d0", r0_data, 32'd0);
    check("e_idle_e0", 32'(r0_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
